// File: rtl/rv32i_instr_encoder_if.sv
// Instruction-encoder bus: valid/ready field input side plus the
// one-cycle write strobe toward instruction memory.
// master = program loader driving fields; slave = the encoder.
interface rv32i_instr_encoder_if #(
    parameter int AW = 3
);
    logic          i_valid;
    logic          o_ready;
    logic [3:0]    i_class;
    logic [4:0]    i_rd;
    logic [4:0]    i_rs1;
    logic [4:0]    i_rs2;
    logic [2:0]    i_funct3;
    logic [6:0]    i_funct7;
    logic [31:0]   i_imm;
    logic          i_clear;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [31:0]   o_wr_data;
    logic          o_full;
    logic          o_err;

    modport master (
        output i_valid, i_class, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_clear,
        input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_full, o_err
    );

    modport slave (
        input  i_valid, i_class, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_clear,
        output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_full, o_err
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder / sequential instruction-memory writer.
// Accepts class + fields on a valid/ready handshake, encodes one 32-bit
// word, and writes it at the next address with a one-cycle strobe.
// Flow per word: IDLE (accept) -> ENCODE -> WRITE -> IDLE, or FULL after
// the last address. Optional build macro IMM_RANGE_CHECK_EN: reject
// immediates that do not fit their format instead of truncating them.
module rv32i_instr_encoder #(
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    rv32i_instr_encoder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_FULL   = 2'd3;

    localparam logic [3:0] CLS_ALU_R  = 4'd0;
    localparam logic [3:0] CLS_ALU_I  = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;
    localparam logic [3:0] CLS_SYSTEM = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    logic [1:0]    state_q,   state_d;
    logic [AW-1:0] cnt_q,     cnt_d;
    logic          err_q,     err_d;
    logic [31:0]   wr_data_q, wr_data_d;
    fields_t       fields_q,  fields_d;

    logic [31:0]   enc_data;
    logic          enc_err;
    logic          rng_i_ok;
    logic          rng_b_ok;
    logic          rng_j_ok;
    logic          rng_u_ok;

`ifdef IMM_RANGE_CHECK_EN
    // A signed value fits N bits when all bits above N-1 equal the sign bit.
    assign rng_i_ok = (&fields_q.imm[31:11]) | ~(|fields_q.imm[31:11]);
    assign rng_b_ok = ((&fields_q.imm[31:12]) | ~(|fields_q.imm[31:12])) & ~fields_q.imm[0];
    assign rng_j_ok = ((&fields_q.imm[31:20]) | ~(|fields_q.imm[31:20])) & ~fields_q.imm[0];
    assign rng_u_ok = ~(|fields_q.imm[11:0]);
`else
    assign rng_i_ok = 1'b1;
    assign rng_b_ok = 1'b1;
    assign rng_j_ok = 1'b1;
    assign rng_u_ok = 1'b1;
`endif

    // Encode the captured fields into an instruction word and flag errors.
    always_comb begin
        enc_data = '0;
        enc_err  = 1'b0;
        case (fields_q.cls)
            CLS_ALU_R: begin
                enc_data = {fields_q.f7, fields_q.rs2, fields_q.rs1, fields_q.f3,
                            fields_q.rd, OP_R};
            end
            CLS_ALU_I, CLS_LOAD, CLS_JALR, CLS_SYSTEM: begin
                enc_data = {fields_q.imm[11:0], fields_q.rs1, fields_q.f3, fields_q.rd, OP_ALU_I};
                case (fields_q.cls)
                    CLS_LOAD:   enc_data[6:0] = OP_LOAD;
                    CLS_JALR:   enc_data[6:0] = OP_JALR;
                    CLS_SYSTEM: enc_data[6:0] = OP_SYSTEM;
                    default:    enc_data[6:0] = OP_ALU_I;
                endcase
                enc_err = ~rng_i_ok;
            end
            CLS_STORE: begin
                enc_data = {fields_q.imm[11:5], fields_q.rs2, fields_q.rs1, fields_q.f3,
                            fields_q.imm[4:0], OP_STORE};
                enc_err  = ~rng_i_ok;
            end
            CLS_BRANCH: begin
                enc_data = {fields_q.imm[12], fields_q.imm[10:5], fields_q.rs2, fields_q.rs1,
                            fields_q.f3, fields_q.imm[4:1], fields_q.imm[11], OP_BRANCH};
                enc_err  = ~rng_b_ok;
            end
            CLS_JAL: begin
                enc_data = {fields_q.imm[20], fields_q.imm[10:1], fields_q.imm[11],
                            fields_q.imm[19:12], fields_q.rd, OP_JAL};
                enc_err  = ~rng_j_ok;
            end
            CLS_LUI: begin
                enc_data = {fields_q.imm[31:12], fields_q.rd, OP_LUI};
                enc_err  = ~rng_u_ok;
            end
            CLS_AUIPC: begin
                enc_data = {fields_q.imm[31:12], fields_q.rd, OP_AUIPC};
                enc_err  = ~rng_u_ok;
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    // Next-state logic; i_clear overrides every transition and drops any in-flight word.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        wr_data_d = wr_data_q;
        fields_d  = fields_q;
        if (bus.i_clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        fields_d.cls = bus.i_class;
                        fields_d.rd  = bus.i_rd;
                        fields_d.rs1 = bus.i_rs1;
                        fields_d.rs2 = bus.i_rs2;
                        fields_d.f3  = bus.i_funct3;
                        fields_d.f7  = bus.i_funct7;
                        fields_d.imm = bus.i_imm;
                        state_d      = ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (enc_err) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wr_data_d = enc_data;
                        state_d   = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_FULL;
                    end else begin
                        cnt_d   = cnt_q + AW'(1);
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_FULL;
                end
            endcase
        end
    end

    // State registers; async reset discards any in-flight word.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_data_q <= '0;
            fields_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_data_q <= wr_data_d;
            fields_q  <= fields_d;
        end
    end

    // Strobe, ready and full decode straight from state so reset clears them at once.
    assign bus.o_ready   = (state_q == ST_IDLE);
    assign bus.o_wr_en   = (state_q == ST_WRITE);
    assign bus.o_full    = (state_q == ST_FULL);
    assign bus.o_wr_addr = cnt_q;
    assign bus.o_wr_data = wr_data_q;
    assign bus.o_err     = err_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed cases from the
// encoder's documented examples, then randomized fields compared against
// a shift/mask reference model of the RV32I formats.
module tb_rv32i_instr_encoder;

    localparam int DEPTH = 5;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    rv32i_instr_encoder_if #(.AW(AW)) bus ();

    rv32i_instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_cnt    = 0;
    bit          m_full   = 1'b0;
    logic [31:0] m_last   = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bit model_bad(input int unsigned cls, input logic [31:0] imm);
        int s;
        s = imm;
        if (cls > 9) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        case (cls)
            1, 2, 3, 6, 9: return !(s >= -2048 && s <= 2047);
            4:             return !(s >= -4096 && s <= 4094 && imm[0] == 1'b0);
            5:             return !(s >= -(1 << 20) && s <= (1 << 20) - 2 && imm[0] == 1'b0);
            7, 8:          return (imm % 4096) != 0;
            default:       return 1'b0;
        endcase
`else
        return s < 0 && s > 0;
`endif
    endfunction

    function automatic logic [31:0] model_enc(input int unsigned cls, rd, rs1, rs2, f3, f7,
                                              input logic [31:0] imm);
        logic [31:0] r;
        r = '0;
        case (cls)
            0: r = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            1: r = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            2: r = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
            6: r = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h67;
            9: r = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h73;
            3: r = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | 32'h23;
            4: r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 1) << 7) | 32'h63;
            5: r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | 32'h6F;
            7: r = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
            8: r = (imm & 32'hFFFFF000) | (rd << 7) | 32'h17;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic drive_fields(input int unsigned cls, rd, rs1, rs2, f3, f7, input logic [31:0] imm);
        bus.i_class  = 4'(cls);
        bus.i_rd     = 5'(rd);
        bus.i_rs1    = 5'(rs1);
        bus.i_rs2    = 5'(rs2);
        bus.i_funct3 = 3'(f3);
        bus.i_funct7 = 7'(f7);
        bus.i_imm    = imm;
        bus.i_valid  = 1'b1;
    endtask

    // Called and returns at a falling edge; one full accept/encode/write transaction.
    task automatic send(input int unsigned cls, rd, rs1, rs2, f3, f7, input logic [31:0] imm,
                        output logic [31:0] got);
        bit          bad;
        logic [31:0] exp;
        bad = model_bad(cls, imm);
        exp = model_enc(cls, rd, rs1, rs2, f3, f7, imm);
        check("ready_before", {31'b0, bus.o_ready}, 32'd1);
        drive_fields(cls, rd, rs1, rs2, f3, f7, imm);
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("enc_wr_en",   {31'b0, bus.o_wr_en}, 32'd0);
        check("enc_ready",   {31'b0, bus.o_ready}, 32'd0);
        check("enc_err",     {31'b0, bus.o_err},   32'd0);
        check("enc_hold",    bus.o_wr_data, m_last);
        @(negedge clk);
        got = bus.o_wr_data;
        if (bad) begin
            check("err_pulse",  {31'b0, bus.o_err},   32'd1);
            check("err_no_wr",  {31'b0, bus.o_wr_en}, 32'd0);
        end else begin
            check("wr_en",      {31'b0, bus.o_wr_en}, 32'd1);
            check("wr_addr",    32'(bus.o_wr_addr), 32'(m_cnt));
            check("wr_data",    bus.o_wr_data, exp);
            check("wr_no_err",  {31'b0, bus.o_err}, 32'd0);
            m_last = exp;
            if (m_cnt == DEPTH - 1) m_full = 1'b1;
            else                    m_cnt++;
        end
        @(negedge clk);
        check("post_wr_en", {31'b0, bus.o_wr_en}, 32'd0);
        check("post_err",   {31'b0, bus.o_err},   32'd0);
        check("post_full",  {31'b0, bus.o_full},  {31'b0, m_full});
        check("post_ready", {31'b0, bus.o_ready}, {31'b0, ~m_full});
        check("post_addr",  32'(bus.o_wr_addr), 32'(m_cnt));
        check("post_hold",  bus.o_wr_data, m_last);
    endtask

    task automatic do_clear();
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        m_cnt  = 0;
        m_full = 1'b0;
        check("clr_ready", {31'b0, bus.o_ready}, 32'd1);
        check("clr_full",  {31'b0, bus.o_full},  32'd0);
        check("clr_addr",  32'(bus.o_wr_addr), 32'd0);
        check("clr_wr_en", {31'b0, bus.o_wr_en}, 32'd0);
        check("clr_hold",  bus.o_wr_data, m_last);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, {31'b0, bus.o_ready}, 32'd1);
        check({tag, "_wr_en"}, {31'b0, bus.o_wr_en}, 32'd0);
        check({tag, "_full"},  {31'b0, bus.o_full},  32'd0);
        check({tag, "_err"},   {31'b0, bus.o_err},   32'd0);
        check({tag, "_addr"},  32'(bus.o_wr_addr), 32'd0);
        check({tag, "_data"},  bus.o_wr_data, 32'd0);
    endtask

    logic [31:0] imm_edges [14] = '{
        32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, -32'sd4096,
        -32'sd4098, 32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'hFFEFFFFE,
        32'h12345000, 32'h12345001
    };

    initial begin
        logic [31:0] got;
        int unsigned cls;
        logic [31:0] imm;

        nrst         = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_clear  = 1'b0;
        bus.i_class  = '0;
        bus.i_rd     = '0;
        bus.i_rs1    = '0;
        bus.i_rs2    = '0;
        bus.i_funct3 = '0;
        bus.i_funct7 = '0;
        bus.i_imm    = '0;
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        nrst = 1'b1;
        @(negedge clk);

        send(0, 1, 0, 0, 0, 0, 32'd0, got);
        check("first_alu_r", got, 32'h000000B3);
        send(1, 1, 1, 0, 0, 0, 32'd1, got);
        check("addi", got, 32'h00108093);
        send(2, 2, 1, 0, 2, 0, 32'd0, got);
        check("lw", got, 32'h0000A103);
        send(3, 0, 1, 2, 2, 0, 32'd0, got);
        check("sw", got, 32'h0020A023);
        send(9, 0, 0, 0, 0, 0, 32'd1, got);
        check("ebreak", got, 32'h00100073);
        check("full_after5",  {31'b0, bus.o_full},  32'd1);
        check("ready_after5", {31'b0, bus.o_ready}, 32'd0);
        check("addr_after5",  32'(bus.o_wr_addr), 32'd4);

        do_clear();

        send(5, 1, 0, 0, 0, 0, 32'd8, got);
        check("jal", got, 32'h008000EF);

        send(1, 1, 1, 0, 0, 0, 32'd2048, got);
`ifndef IMM_RANGE_CHECK_EN
        check("addi_2048", got, 32'h80008093);
`endif

        send(12, 3, 4, 5, 1, 0, 32'd0, got);

        // Clear while the word is in ENCODE: dropped, no write, no error.
        drive_fields(0, 7, 8, 9, 0, 0, 32'd0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        m_cnt  = 0;
        m_full = 1'b0;
        check("clrenc_wr_en", {31'b0, bus.o_wr_en}, 32'd0);
        check("clrenc_err",   {31'b0, bus.o_err},   32'd0);
        check("clrenc_ready", {31'b0, bus.o_ready}, 32'd1);
        check("clrenc_addr",  32'(bus.o_wr_addr), 32'd0);
        @(negedge clk);
        check("clrenc_wr_en2", {31'b0, bus.o_wr_en}, 32'd0);
        check("clrenc_hold",   bus.o_wr_data, m_last);

        send(7, 3, 0, 0, 0, 0, 32'hABCDE000, got);

        // Asynchronous reset while the write strobe is up.
        drive_fields(0, 2, 3, 4, 5, 32, 32'd0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_wr_en", {31'b0, bus.o_wr_en}, 32'd1);
        nrst = 1'b0;
        #1;
        m_cnt  = 0;
        m_full = 1'b0;
        m_last = '0;
        check_reset_state("midrst");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            if (m_full || $urandom_range(0, 9) == 0) do_clear();
            if ($urandom_range(0, 7) == 0) cls = $urandom_range(10, 15);
            else                           cls = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = imm_edges[$urandom_range(0, 13)];
            endcase
            send(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 7), $urandom_range(0, 127), imm, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
